alu_op_sequencer: RTL and testbench

//  Multi-cycle command sequencer in front of one shared combinational ALU (5-bit controls, 3-bit flags).

---
 rtl/alu_op_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one command at a time and walks it through one shared combinational ALU.
// Native ops take one pass. SUB takes two ADD passes. MUL is a shift-add loop that keeps the low 32 bits.
module alu_op_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       alu_flags
);
    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CTRL_W  = 5;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SRL  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRA  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DIFF = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(8);

    localparam logic [CTRL_W-1:0] CTRL_ADD      = 5'b00000;
    localparam logic [CTRL_W-1:0] CTRL_AND      = 5'b00001;
    localparam logic [CTRL_W-1:0] CTRL_XOR      = 5'b00010;
    localparam logic [CTRL_W-1:0] CTRL_SLL      = 5'b00011;
    localparam logic [CTRL_W-1:0] CTRL_SRL      = 5'b00111;
    localparam logic [CTRL_W-1:0] CTRL_SRA      = 5'b01111;
    localparam logic [CTRL_W-1:0] CTRL_DIFF     = 5'b10000;
    localparam logic [CTRL_W-1:0] CTRL_ADD_NOTB = 5'b01000;
    localparam logic [CTRL_W-1:0] CTRL_INC_B    = 5'b00100;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE, S_EXEC, S_SUB2, S_MUL_ADD, S_MUL_SHIFT, S_DONE
    } state_t;

    state_t             r_state, w_next;
    logic [OP_W-1:0]    r_op, w_op_n;
    logic [WIDTH-1:0]   r_opa, w_opa_n;   // also the multiplicand during MUL
    logic [WIDTH-1:0]   r_opb, w_opb_n;   // also the multiplier during MUL
    logic [WIDTH-1:0]   r_acc, w_acc_n;   // MUL accumulator, or A+~B between the two SUB passes
    logic               r_c1, w_c1_n;
    logic [WIDTH-1:0]   r_result;
    logic [2:0]         r_flags;
    logic               r_err;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic               w_legal;
    logic               w_fin;
    logic [WIDTH-1:0]   w_fin_res;
    logic               w_fin_carry;
    logic               w_fin_err;
    logic               w_unused_flags;

    // Zero and sign are rebuilt from the final result, so the ALU's copies are not used.
    assign w_unused_flags = &{1'b0, alu_flags[1:0]};

    assign w_legal = (cmd_op <= OP_DIFF) || (MUL_EN && (cmd_op == OP_MUL));

    function automatic logic [CTRL_W-1:0] f_single_ctrl(input logic [OP_W-1:0] op);
        case (op)
            OP_AND:  return CTRL_AND;
            OP_XOR:  return CTRL_XOR;
            OP_SLL:  return CTRL_SLL;
            OP_SRL:  return CTRL_SRL;
            OP_SRA:  return CTRL_SRA;
            OP_DIFF: return CTRL_DIFF;
            default: return CTRL_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state, ALU drive and datapath updates.
    always_comb begin
        w_next      = r_state;
        w_op_n      = r_op;
        w_opa_n     = r_opa;
        w_opb_n     = r_opb;
        w_acc_n     = r_acc;
        w_c1_n      = r_c1;
        w_fin       = 1'b0;
        w_fin_res   = '0;
        w_fin_carry = 1'b0;
        w_fin_err   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = CTRL_ADD;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_op_n  = cmd_op;
                    w_opa_n = cmd_a;
                    w_opb_n = cmd_b;
                    w_acc_n = '0;
                    w_c1_n  = 1'b0;
                    if (!w_legal) begin
                        w_next    = S_DONE;
                        w_fin     = 1'b1;
                        w_fin_err = 1'b1;
                    end else if (cmd_op == OP_MUL) begin
                        if (cmd_b == '0) begin
                            w_next = S_DONE;
                            w_fin  = 1'b1;
                        end else if (cmd_b[0]) begin
                            w_next = S_MUL_ADD;
                        end else begin
                            w_next = S_MUL_SHIFT;
                        end
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                alu_a = r_opa;
                alu_b = r_opb;
                if (r_op == OP_SUB) begin
                    alu_ctrl = CTRL_ADD_NOTB;
                    w_acc_n  = alu_result;
                    w_c1_n   = alu_flags[2];
                    w_next   = S_SUB2;
                end else begin
                    alu_ctrl    = f_single_ctrl(r_op);
                    w_fin       = 1'b1;
                    w_fin_res   = alu_result;
                    w_fin_carry = alu_flags[2];
                    w_next      = S_DONE;
                end
            end
            S_SUB2: begin
                // Either carry set means A >= B unsigned.
                alu_b       = r_acc;
                alu_ctrl    = CTRL_INC_B;
                w_fin       = 1'b1;
                w_fin_res   = alu_result;
                w_fin_carry = r_c1 | alu_flags[2];
                w_next      = S_DONE;
            end
            S_MUL_ADD: begin
                alu_a    = r_acc;
                alu_b    = r_opa;
                alu_ctrl = CTRL_ADD;
                w_acc_n  = alu_result;
                if (r_opb[WIDTH-1:1] == '0) begin
                    w_fin     = 1'b1;
                    w_fin_res = alu_result;
                    w_next    = S_DONE;
                end else begin
                    w_next = S_MUL_SHIFT;
                end
            end
            S_MUL_SHIFT: begin
                alu_a    = r_opa;
                alu_b    = WIDTH'(1);
                alu_ctrl = CTRL_SLL;
                w_opa_n  = alu_result;
                w_opb_n  = r_opb >> 1;
                w_next   = r_opb[1] ? S_MUL_ADD : S_MUL_SHIFT;
            end
            S_DONE: begin
                if (rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand/response registers; handshake outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_c1        <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_op  <= w_op_n;
            r_opa <= w_opa_n;
            r_opb <= w_opb_n;
            r_acc <= w_acc_n;
            r_c1  <= w_c1_n;
            if (w_fin) begin
                r_result <= w_fin_res;
                r_flags  <= {w_fin_carry, (w_fin_res == '0), w_fin_res[WIDTH-1]};
                r_err    <= w_fin_err;
            end
            r_cmd_ready <= (w_next == S_IDLE);
            r_rsp_valid <= (w_next == S_DONE);
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a bench-side ALU, a command-level reference model,
// a driver that pushes expectations and a monitor that checks responses.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [2:0]  alu_flags;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int bp_mode  = 0;   // 0: rsp_ready high, 1: random, 2: held low

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic have_cur  = 1'b0;
    logic was_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_sequencer #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // Bench-side ALU; DIFF here returns half the absolute difference.
    logic [31:0] ea, eb, ar;
    logic [32:0] asum;
    logic        ac;
    always_comb begin
        ea   = alu_ctrl[2] ? 32'd1 : alu_a;
        eb   = alu_ctrl[3] ? ~alu_b : alu_b;
        asum = {1'b0, ea} + {1'b0, eb};
        ar   = '0;
        ac   = 1'b0;
        if (alu_ctrl[4]) begin
            ar = ((alu_a > alu_b) ? (alu_a - alu_b) : (alu_b - alu_a)) >> 1;
        end else begin
            case (alu_ctrl[1:0])
                2'b00: begin ar = asum[31:0]; ac = asum[32]; end
                2'b01: ar = ea & eb;
                2'b10: ar = ea ^ eb;
                default: begin
                    case (alu_ctrl[3:2])
                        2'b00:   ar = alu_a << alu_b[4:0];
                        2'b01:   ar = alu_a >> alu_b[4:0];
                        2'b11:   ar = 32'($signed(alu_a) >>> alu_b[4:0]);
                        default: ar = '0;
                    endcase
                end
            endcase
        end
    end
    assign alu_result = ar;
    assign alu_flags  = {ac, (ar == 32'd0), ar[31]};

    // Command-level reference: what each opcode means, plus its cycle cost.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic        c;
        logic [32:0] s;
        int          pc;
        int          msb;
        c = 1'b0; pc = 0; msb = 0;
        e.res = '0; e.err = 1'b0; e.lat = 2; e.acc = 0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; c = s[32]; end
            4'd1: begin e.res = a - b; c = (a >= b); e.lat = 3; end
            4'd2: e.res = a & b;
            4'd3: e.res = a ^ b;
            4'd4: e.res = a << b[4:0];
            4'd5: e.res = a >> b[4:0];
            4'd6: e.res = 32'($signed(a) >>> b[4:0]);
            4'd7: e.res = ((a > b) ? (a - b) : (b - a)) >> 1;
            4'd8: begin
                e.res = a * b;
                for (int i = 0; i < 32; i++) if (b[i]) begin pc++; msb = i; end
                e.lat = (b == 32'd0) ? 1 : (1 + pc + msb);
            end
            default: begin e.err = 1'b1; e.lat = 1; end
        endcase
        e.flags = {c, (e.res == 32'd0), e.res[31]};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    // Monitor: pop an expectation when a response appears, check it every cycle it is held.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                if (!was_valid) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_err++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_rsp: got result 0x%08h with no command outstanding", rsp_result);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1'b1;
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end
                if (have_cur) begin
                    chk("result", rsp_result, cur.res);
                    chk("flags", 32'(rsp_flags), 32'(cur.flags));
                    chk("err", 32'(rsp_err), 32'(cur.err));
                end
            end else if (cmd_ready) begin
                chk("alu_ctrl_idle", 32'(alu_ctrl), 32'd0);
            end
            was_valid = rsp_valid;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        t = 0;
        while (!cmd_ready && t < 300) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, t);
            cmd_valid = 1'b0;
            return;
        end
        e = model(op, a, b);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || rsp_valid) && t < 600) begin @(negedge clk); t++; end
        if (sb.size() != 0 || rsp_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        int          k;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(4'd0, 32'd5, 32'd7);
        issue(4'd1, 32'd3, 32'd5);
        issue(4'd1, 32'd5, 32'd5);
        issue(4'd8, 32'd6, 32'd7);
        issue(4'd8, 32'h1234, 32'd0);
        issue(4'd8, 32'h10000, 32'h10000);
        issue(4'd6, 32'h80000000, 32'd4);
        issue(4'd7, 32'h0C, 32'h08);
        issue(4'hF, 32'h55, 32'hAA);
        issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(4'd0, 32'hFFFFFFFF, 32'd1);
        issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        issue(4'd3, 32'hDEAD_BEEF, 32'hFFFF_0000);
        issue(4'd4, 32'h0000_0003, 32'd31);
        issue(4'd5, 32'h8000_0000, 32'd31);
        issue(4'd1, 32'd0, 32'd1);
        drain();

        // Held response with a competing command on the bus.
        bp_mode = 2;
        issue(4'd0, 32'h100, 32'h23);
        t = 0;
        while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 4'd3; cmd_a = $urandom; cmd_b = $urandom;
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        bp_mode = 0;
        drain();

        // Reset in the middle of a MUL drops it without a response.
        issue(4'd8, 32'd6, 32'd7);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        repeat (8) @(negedge clk);
        issue(4'd0, 32'd40, 32'd2);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            k  = $urandom_range(0, 9);
            op = (k == 9) ? 4'($urandom_range(9, 15)) : 4'(k);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = b & 32'h0000_00FF;
                1:       a = b;
                default: ;
            endcase
            issue(op, a, b);
        end
        bp_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
